riscv_multicycle_controller: RTL and testbench

- Multicycle successor to the single-cycle RV32 controller: a state machine sequencing FETCH/DECODE/EXECUTE/MEM/WB over a shared-memory datapath.
- Adds memory ready handshake, BNE/BGE, and parametrised multi-cycle MUL/DIV stall.
- Illegal-instruction trap state.
- Sits between the instruction register/ALU flags and the multicycle datapath muxes and write enables.

---
 rtl/riscv_ctrl_pkg.sv | 82 ++++++++
 rtl/riscv_alu_decode.sv | 46 ++++
 rtl/riscv_multicycle_controller.sv | 188 ++++++++++++++++++
 tb/tb_riscv_multicycle_controller.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the multicycle RV32 controller: opcodes, ALU codes,
// state encoding, datapath mux selects and the packed control-word type.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b1010;
  localparam logic [3:0] ALU_SLT = 4'b1011;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b0100;
  localparam logic [3:0] ALU_DIV = 4'b0101;

  localparam logic [3:0] ST_FETCH   = 4'd0;
  localparam logic [3:0] ST_DECODE  = 4'd1;
  localparam logic [3:0] ST_MEMADDR = 4'd2;
  localparam logic [3:0] ST_MEMRD   = 4'd3;
  localparam logic [3:0] ST_MEMWB   = 4'd4;
  localparam logic [3:0] ST_MEMWR   = 4'd5;
  localparam logic [3:0] ST_EXEC_R  = 4'd6;
  localparam logic [3:0] ST_EXEC_I  = 4'd7;
  localparam logic [3:0] ST_AUIPC   = 4'd8;
  localparam logic [3:0] ST_ALUWB   = 4'd9;
  localparam logic [3:0] ST_BRANCH  = 4'd10;
  localparam logic [3:0] ST_JAL     = 4'd11;
  localparam logic [3:0] ST_TRAP    = 4'd12;

  typedef enum logic [3:0] {
    S_FETCH   = ST_FETCH,
    S_DECODE  = ST_DECODE,
    S_MEMADDR = ST_MEMADDR,
    S_MEMRD   = ST_MEMRD,
    S_MEMWB   = ST_MEMWB,
    S_MEMWR   = ST_MEMWR,
    S_EXEC_R  = ST_EXEC_R,
    S_EXEC_I  = ST_EXEC_I,
    S_AUIPC   = ST_AUIPC,
    S_ALUWB   = ST_ALUWB,
    S_BRANCH  = ST_BRANCH,
    S_JAL     = ST_JAL,
    S_TRAP    = ST_TRAP
  } state_e;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;
  localparam logic [1:0] ASA_PC     = 2'b00;
  localparam logic [1:0] ASA_OLDPC  = 2'b01;
  localparam logic [1:0] ASA_RS1    = 2'b10;
  localparam logic [1:0] ASB_RS2    = 2'b00;
  localparam logic [1:0] ASB_IMM    = 2'b01;
  localparam logic [1:0] ASB_FOUR   = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       irwrite;
    logic       adrsrc;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic [1:0] alusrc_a;
    logic [1:0] alusrc_b;
    logic [1:0] resultsrc;
    logic [3:0] alucontrol;
  } ctrl_t;

  // BEQ/BLT always exist; BNE/BGE only with the extended branch set.
  function automatic logic branch_legal(logic [2:0] f3, logic en_ext);
    return (f3 == 3'b000) || (f3 == 3'b100) ||
           (en_ext && ((f3 == 3'b001) || (f3 == 3'b101)));
  endfunction

endpackage

// File: rtl/riscv_alu_decode.sv
// R-type funct7/funct3 to ALU control, with a legality flag and a MUL/DIV
// marker used by the controller to hold the execute state.
module riscv_alu_decode
  import riscv_ctrl_pkg::*;
#(
  parameter bit EN_MULDIV = 1'b1
) (
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output logic [3:0] alucontrol,
  output logic       legal,
  output logic       is_muldiv
);

  always_comb begin
    alucontrol = ALU_ADD;
    legal      = 1'b0;
    is_muldiv  = 1'b0;
    case (funct7)
      7'b0000000: begin
        case (funct3)
          3'b000: begin alucontrol = ALU_ADD; legal = 1'b1; end
          3'b010: begin alucontrol = ALU_SLT; legal = 1'b1; end
          3'b110: begin alucontrol = ALU_OR;  legal = 1'b1; end
          3'b111: begin alucontrol = ALU_AND; legal = 1'b1; end
          default: ;
        endcase
      end
      7'b0100000: begin
        if (funct3 == 3'b000) begin
          alucontrol = ALU_SUB;
          legal      = 1'b1;
        end
      end
      7'b0000001: begin
        case (funct3)
          3'b000: begin alucontrol = ALU_MUL; legal = EN_MULDIV; is_muldiv = 1'b1; end
          3'b100: begin alucontrol = ALU_DIV; legal = EN_MULDIV; is_muldiv = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_controller.sv
// Multicycle RV32 controller: FETCH/DECODE/EXECUTE/MEM/WB sequencing over a
// shared-memory datapath. mem_ready completes the pending memory request in the
// same cycle; requests stay asserted until it does.
module riscv_multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = 4,
  parameter bit          EN_MULDIV     = 1'b1,
  parameter bit          EN_EXT_BRANCH = 1'b1
) (
  input  logic        clock,
  input  logic        reset_,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        lt,
  input  logic        mem_ready,
  output logic        pcwrite,
  output logic        irwrite,
  output logic        adrsrc,
  output logic        memread,
  output logic        memwrite,
  output logic        regwrite,
  output logic [1:0]  alusrcA,
  output logic [1:0]  alusrcB,
  output logic [1:0]  resultsrc,
  output logic [3:0]  alucontrol,
  output logic        illegal,
  output logic [3:0]  state
);

  localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       illegal_q, illegal_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [3:0] r_alu;
  logic       r_legal;
  logic       r_muldiv;
  logic       branch_taken;
  ctrl_t      ctrl;
  ctrl_t      ctrl_o;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[24:15], instr[11:7]};

  riscv_alu_decode #(.EN_MULDIV(EN_MULDIV)) u_alu_decode (
    .funct7     (instr[31:25]),
    .funct3     (funct3),
    .alucontrol (r_alu),
    .legal      (r_legal),
    .is_muldiv  (r_muldiv)
  );

  always_comb begin
    case (funct3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = ~zero;
      3'b100:  branch_taken = lt;
      3'b101:  branch_taken = ~lt;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADDR;
          OP_R: begin
            state_d = S_EXEC_R;
            cnt_d   = MD_LOAD;
          end
          OP_IMM:    state_d = S_EXEC_I;
          OP_AUIPC:  state_d = S_AUIPC;
          OP_JAL:    state_d = S_JAL;
          OP_BRANCH: state_d = branch_legal(funct3, EN_EXT_BRANCH) ? S_BRANCH : S_TRAP;
          default:   state_d = S_TRAP;
        endcase
      end
      S_MEMADDR: state_d = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_EXEC_R: begin
        // MUL/DIV holds here until the counter loaded on entry reaches zero.
        if (!r_legal) begin
          state_d = S_TRAP;
        end else if (!r_muldiv || (cnt_q == 4'd0)) begin
          state_d = S_ALUWB;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_EXEC_I, S_AUIPC:         state_d = S_ALUWB;
      S_ALUWB, S_BRANCH, S_JAL:  state_d = S_FETCH;
      S_TRAP:                    state_d = S_TRAP;
      default:                   state_d = S_FETCH;
    endcase
    if (state_d == S_TRAP) illegal_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_q   <= S_FETCH;
      cnt_q     <= 4'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.memread    = 1'b1;
        ctrl.adrsrc     = ADR_PC;
        ctrl.alusrc_a   = ASA_PC;
        ctrl.alusrc_b   = ASB_FOUR;
        ctrl.alucontrol = ALU_ADD;
        ctrl.irwrite    = mem_ready;
        ctrl.pcwrite    = mem_ready;
      end
      S_DECODE, S_AUIPC: begin
        ctrl.alusrc_a   = ASA_OLDPC;
        ctrl.alusrc_b   = ASB_IMM;
        ctrl.alucontrol = ALU_ADD;
      end
      S_MEMADDR, S_EXEC_I: begin
        ctrl.alusrc_a   = ASA_RS1;
        ctrl.alusrc_b   = ASB_IMM;
        ctrl.alucontrol = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.adrsrc  = ADR_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.regwrite  = 1'b1;
        ctrl.resultsrc = RES_MEM;
      end
      S_MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.adrsrc   = ADR_ALUOUT;
      end
      S_EXEC_R: begin
        ctrl.alusrc_a   = ASA_RS1;
        ctrl.alusrc_b   = ASB_RS2;
        ctrl.alucontrol = r_alu;
      end
      S_ALUWB: begin
        ctrl.regwrite  = 1'b1;
        ctrl.resultsrc = RES_ALUOUT;
      end
      S_BRANCH: begin
        ctrl.alusrc_a   = ASA_RS1;
        ctrl.alusrc_b   = ASB_RS2;
        ctrl.resultsrc  = RES_ALUOUT;
        ctrl.alucontrol = funct3[2] ? ALU_SLT : ALU_SUB;
        ctrl.pcwrite    = branch_taken;
      end
      S_JAL: begin
        ctrl.pcwrite   = 1'b1;
        ctrl.regwrite  = 1'b1;
        ctrl.resultsrc = RES_ALUOUT;
      end
      default: ;
    endcase
  end

  assign ctrl_o = reset_ ? ctrl : '0;
  assign {pcwrite, irwrite, adrsrc, memread, memwrite, regwrite,
          alusrcA, alusrcB, resultsrc, alucontrol} = ctrl_o;
  assign illegal = reset_ & illegal_q;
  assign state   = reset_ ? state_q : 4'd0;

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Bench for riscv_multicycle_controller: three parameter variants driven with
// directed and random instructions, checked cycle by cycle against a phase list.
module tb_riscv_multicycle_controller;
  import riscv_ctrl_pkg::*;

  // Instance g uses CYC[g*4+:4], EN_MD[g], EN_EXT[g].
  localparam logic [11:0] CYC    = {4'd1, 4'd15, 4'd4};
  localparam logic [2:0]  EN_MD  = 3'b011;
  localparam logic [2:0]  EN_EXT = 3'b101;
  localparam logic [20:0] ALU_MASK_OFF = 21'h1FFE1F;

  logic        clock = 1'b0;
  logic [2:0]  rst_n;
  logic [31:0] instr;
  logic        zero, lt, mem_ready;
  logic [20:0] obs [3];

  int errors = 0;
  int checks = 0;
  int fixed_stall = -1;
  int zl_force = -1;
  state_e ph_q[$];

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic pcw, irw, adr, mrd, mwr, rw, ill;
    logic [1:0] asa, asb, rs;
    logic [3:0] alu, st;
    riscv_multicycle_controller #(
      .MULDIV_CYCLES (int'(CYC[g*4 +: 4])),
      .EN_MULDIV     (EN_MD[g]),
      .EN_EXT_BRANCH (EN_EXT[g])
    ) u_dut (
      .clock      (clock),
      .reset_     (rst_n[g]),
      .instr      (instr),
      .zero       (zero),
      .lt         (lt),
      .mem_ready  (mem_ready),
      .pcwrite    (pcw),
      .irwrite    (irw),
      .adrsrc     (adr),
      .memread    (mrd),
      .memwrite   (mwr),
      .regwrite   (rw),
      .alusrcA    (asa),
      .alusrcB    (asb),
      .resultsrc  (rs),
      .alucontrol (alu),
      .illegal    (ill),
      .state      (st)
    );
    assign obs[g] = {pcw, irw, adr, mrd, mwr, rw, asa, asb, rs, alu, ill, st};
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // R-type table: legality, MUL/DIV class and ALU code.
  function automatic void ref_r(logic [31:0] ins, bit en_md, output bit legal,
                                output bit md, output logic [3:0] code);
    legal = 1'b1; md = 1'b0; code = 4'b0010;
    case ({ins[31:25], ins[14:12]})
      {7'h00, 3'd0}: code = 4'b0010;
      {7'h00, 3'd2}: code = 4'b1011;
      {7'h00, 3'd6}: code = 4'b0001;
      {7'h00, 3'd7}: code = 4'b0000;
      {7'h20, 3'd0}: code = 4'b1010;
      {7'h01, 3'd0}: begin code = 4'b0100; md = 1'b1; legal = en_md; end
      {7'h01, 3'd4}: begin code = 4'b0101; md = 1'b1; legal = en_md; end
      default:       legal = 1'b0;
    endcase
  endfunction

  function automatic logic [20:0] exp_out(state_e p, logic [31:0] ins, logic mr,
                                          logic z, logic l);
    logic pcw, irw, adr, mrd, mwr, rw, ill;
    logic [1:0] asa, asb, rs;
    logic [3:0] alu, code;
    bit legal, md;
    {pcw, irw, adr, mrd, mwr, rw, ill} = '0;
    asa = '0; asb = '0; rs = '0; alu = '0;
    case (p)
      S_FETCH:  begin mrd = 1; asb = 2'b10; alu = 4'b0010; irw = mr; pcw = mr; end
      S_DECODE, S_AUIPC:   begin asa = 2'b01; asb = 2'b01; alu = 4'b0010; end
      S_MEMADDR, S_EXEC_I: begin asa = 2'b10; asb = 2'b01; alu = 4'b0010; end
      S_MEMRD:  begin mrd = 1; adr = 1; end
      S_MEMWB:  begin rw = 1; rs = 2'b01; end
      S_MEMWR:  begin mwr = 1; adr = 1; end
      S_EXEC_R: begin asa = 2'b10; ref_r(ins, 1'b1, legal, md, code); alu = code; end
      S_ALUWB:  rw = 1;
      S_BRANCH: begin
        asa = 2'b10;
        alu = ins[14] ? 4'b1011 : 4'b1010;
        case (ins[14:12])
          3'b000: pcw = z;
          3'b001: pcw = !z;
          3'b100: pcw = l;
          3'b101: pcw = !l;
          default: pcw = 0;
        endcase
      end
      S_JAL:    begin pcw = 1; rw = 1; end
      S_TRAP:   ill = 1;
      default: ;
    endcase
    return {pcw, irw, adr, mrd, mwr, rw, asa, asb, rs, alu, ill, 4'(p)};
  endfunction

  // Expected phase sequence of one instruction (wait phases repeat on stalls).
  task automatic build(int g, logic [31:0] ins);
    bit legal, md, br_ok;
    logic [3:0] code;
    int n;
    logic [2:0] f3;
    f3 = ins[14:12];
    ph_q.delete();
    ph_q.push_back(S_FETCH);
    ph_q.push_back(S_DECODE);
    case (ins[6:0])
      7'b0000011: begin ph_q.push_back(S_MEMADDR); ph_q.push_back(S_MEMRD); ph_q.push_back(S_MEMWB); end
      7'b0100011: begin ph_q.push_back(S_MEMADDR); ph_q.push_back(S_MEMWR); end
      7'b0110011: begin
        ref_r(ins, EN_MD[g], legal, md, code);
        if (!legal) begin
          ph_q.push_back(S_EXEC_R);
          ph_q.push_back(S_TRAP);
        end else begin
          n = md ? int'(CYC[g*4 +: 4]) : 1;
          repeat (n) ph_q.push_back(S_EXEC_R);
          ph_q.push_back(S_ALUWB);
        end
      end
      7'b0010011: begin ph_q.push_back(S_EXEC_I); ph_q.push_back(S_ALUWB); end
      7'b0010111: begin ph_q.push_back(S_AUIPC); ph_q.push_back(S_ALUWB); end
      7'b1101111: ph_q.push_back(S_JAL);
      7'b1100011: begin
        br_ok = (f3 == 3'd0) || (f3 == 3'd4) || (EN_EXT[g] && ((f3 == 3'd1) || (f3 == 3'd5)));
        ph_q.push_back(br_ok ? S_BRANCH : S_TRAP);
      end
      default: ph_q.push_back(S_TRAP);
    endcase
  endtask

  task automatic rand_zl();
    if (zl_force < 0) begin
      zero = 1'($urandom_range(0, 1));
      lt   = 1'($urandom_range(0, 1));
    end else begin
      {zero, lt} = 2'(zl_force);
    end
  endtask

  task automatic trap_and_reset(int g, logic [31:0] ins);
    for (int i = 0; i < 10; i++) begin
      rand_zl();
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      check($sformatf("g%0d_trap_hold", g), obs[g], exp_out(S_TRAP, ins, mem_ready, zero, lt));
      @(posedge clock); #1;
    end
    rst_n[g] = 1'b0;
    @(negedge clock);
    check($sformatf("g%0d_trap_reset_outs", g), obs[g], 21'h0);
    @(posedge clock); #1;
    rst_n[g] = 1'b1;
  endtask

  task automatic abort_write(int g, logic [31:0] ins);
    mem_ready = 1'b0;
    rst_n[g] = 1'b0;
    @(negedge clock);
    check($sformatf("g%0d_abort_reset_outs", g), obs[g], 21'h0);
    @(posedge clock); #1;
    rst_n[g] = 1'b1;
    @(negedge clock);
    check($sformatf("g%0d_abort_memwrite", g), obs[g][16], 1'b0);
    check($sformatf("g%0d_abort_fetch", g), obs[g], exp_out(S_FETCH, ins, 1'b0, zero, lt));
    @(posedge clock); #1;
  endtask

  task automatic run_instr(int g, logic [31:0] ins, bit abort_wr);
    int idx, stalls;
    state_e p;
    bit waiting, legal, md;
    logic [3:0] code;
    logic [20:0] m;
    build(g, ins);
    ref_r(ins, EN_MD[g], legal, md, code);
    instr = ins;
    idx = 0;
    stalls = 0;
    while (idx < ph_q.size()) begin
      p = ph_q[idx];
      waiting = (p == S_FETCH) || (p == S_MEMRD) || (p == S_MEMWR);
      if (fixed_stall < 0)   mem_ready = (stalls >= 3) || ($urandom_range(0, 2) != 0);
      else if (p == S_FETCH) mem_ready = 1'b1;
      else                   mem_ready = (stalls >= fixed_stall);
      rand_zl();
      if (p == S_TRAP) begin
        trap_and_reset(g, ins);
        return;
      end
      if (abort_wr && (p == S_MEMWR) && (stalls == 2)) begin
        abort_write(g, ins);
        return;
      end
      m = ((p == S_EXEC_R) && !legal) ? ALU_MASK_OFF : '1;
      @(negedge clock);
      check($sformatf("g%0d_%s_%h", g, p.name(), ins), obs[g] & m,
            exp_out(p, ins, mem_ready, zero, lt) & m);
      @(posedge clock); #1;
      if (waiting && !mem_ready) stalls++;
      else begin
        stalls = 0;
        idx++;
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: r[6:0] = 7'b0000011;
      1: r[6:0] = 7'b0100011;
      2: begin
        r[6:0] = 7'b0110011;
        case ($urandom_range(0, 4))
          0: {r[31:25], r[14:12]} = {7'h00, 3'd0};
          1: {r[31:25], r[14:12]} = {7'h00, 3'd2};
          2: {r[31:25], r[14:12]} = {7'h00, 3'd6};
          3: {r[31:25], r[14:12]} = {7'h00, 3'd7};
          default: {r[31:25], r[14:12]} = {7'h20, 3'd0};
        endcase
      end
      3: r[6:0] = 7'b0110011;
      4: r[6:0] = 7'b0010011;
      5: r[6:0] = 7'b0010111;
      6: r[6:0] = 7'b1101111;
      7: r[6:0] = 7'b1100011;
      8: ;
      default: begin
        r[6:0] = 7'b0110011;
        r[31:25] = 7'h01;
        r[14:12] = $urandom_range(0, 1) ? 3'd0 : 3'd4;
      end
    endcase
    return r;
  endfunction

  task automatic random_run(int g, int n);
    fixed_stall = -1;
    zl_force = -1;
    for (int i = 0; i < n; i++) run_instr(g, rand_instr(), 1'b0);
  endtask

  initial begin
    rst_n = 3'b000;
    instr = $urandom;
    zero = 1'b1; lt = 1'b1; mem_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    for (int g = 0; g < 3; g++) check($sformatf("g%0d_reset_outs", g), obs[g], 21'h0);
    @(posedge clock); #1;

    rst_n[0] = 1'b1;
    fixed_stall = 0;
    run_instr(0, 32'h00208033, 1'b0);
    fixed_stall = 2;
    run_instr(0, 32'h00512003, 1'b0);
    fixed_stall = 0;
    zl_force = 0;
    run_instr(0, 32'h00101263, 1'b0);
    zl_force = 2;
    run_instr(0, 32'h00101263, 1'b0);
    zl_force = 1;
    run_instr(0, 32'h00105263, 1'b0);
    zl_force = -1;
    run_instr(0, 32'h02208033, 1'b0);
    run_instr(0, 32'hFFFFFFFF, 1'b0);
    fixed_stall = 5;
    run_instr(0, 32'h000122A3, 1'b1);
    random_run(0, 150);
    rst_n[0] = 1'b0;

    rst_n[1] = 1'b1;
    fixed_stall = 0;
    run_instr(1, 32'h02208033, 1'b0);
    run_instr(1, 32'h00101263, 1'b0);
    random_run(1, 80);
    rst_n[1] = 1'b0;

    rst_n[2] = 1'b1;
    fixed_stall = 0;
    run_instr(2, 32'h02208033, 1'b0);
    run_instr(2, 32'h00105263, 1'b0);
    random_run(2, 80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
